freq_sweep_ctrl: RTL and testbench
==================================

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter FREQ_W, default 16, meaning width of the frequency word driven to the DDS freq input.
REQ-002 SHALL have parameter DWELL_W, default 24, meaning width of the dwell counter in clk_i cycles.
REQ-003 SHALL have port clk_i, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we_i, input, 1 bit: config write strobe; captures all cfg_* inputs.
REQ-006 SHALL have ports cfg_start_i, cfg_stop_i and cfg_step_i, each input, FREQ_W bits: sweep start, stop and step magnitude.
REQ-007 SHALL have port cfg_dwell_i, input, DWELL_W bits: cycles each frequency is held.
REQ-008 SHALL have port cfg_cont_i, input, 1 bit: 0 = single sweep, 1 = continuous sweep.
REQ-009 SHALL have ports go_i and abort_i, each input, 1 bit: sweep start request and sweep abort request.
REQ-010 SHALL have port freq_o, output, FREQ_W bits: frequency word to the DDS.
REQ-011 SHALL have port freq_upd_o, output, 1 bit: 1-cycle pulse in each cycle in which freq_o takes a new value.
REQ-012 SHALL have ports busy_o, done_o and err_o, each output, 1 bit: sweep active; 1-cycle end-of-sweep pulse; sticky config error.

Function
REQ-013 SHALL use an FSM with states IDLE, DWELL and DONE.
REQ-014 SHALL capture cfg_we_i only in IDLE; writes arriving in DWELL or DONE are ignored.
REQ-015 SHALL, on go_i in IDLE at cycle n with step != 0, output freq_o = start and pulse freq_upd_o at cycle n+1, with busy_o = 1 from n+1.
REQ-016 SHALL, on go_i with step == 0, set err_o and remain in IDLE; err_o clears on the next cfg_we_i.
REQ-017 SHALL set direction up if stop >= start, else down, and hold it for the whole sweep.
REQ-018 SHALL treat dwell value 0 as 1; with effective dwell D, every freq_o value is held exactly D cycles.
REQ-019 SHALL compute next = freq_o +/- step in FREQ_W+1 bits; if next passes stop, or overflows or underflows, next = stop (clamp).
REQ-020 SHALL, when the dwell expires on freq_o == stop, pulse done_o and deassert busy_o in the following cycle, then go to IDLE via DONE (DONE lasts one cycle); in continuous mode it SHALL instead reload start with freq_upd_o and no done_o.
REQ-021 SHALL treat start == stop as a single-point sweep.
REQ-022 SHALL, on abort_i in any state, return to IDLE next cycle, with busy_o = 0, no done_o, and freq_o holding its last value; abort_i wins over a simultaneous go_i.
REQ-023 SHALL ignore go_i while busy_o = 1.

Reset
REQ-024 SHALL, on rstn_i low, immediately force state IDLE, freq_o = 0, freq_upd_o = 0, busy_o = 0, done_o = 0, err_o = 0, all config registers = 0 and the dwell counter = 0.
REQ-025 SHALL, on reset mid-sweep, abandon the sweep with no done_o pulse after reset release.

Structure
REQ-026 SHALL take the FSM state encodings and the FREQ_W/DWELL_W defaults from a shared package, sweep_pkg.
REQ-027 SHALL implement the dwell down-counter as sub-module dwell_timer, with load, load value D-1, and 1-cycle expire pulse.

Verification
REQ-028 SHALL cover: start=100, stop=130, step=10, dwell=4, go at n -> freq_upd_o with 100@n+1, 110@n+5, 120@n+9, 130@n+13; done_o @n+17.
REQ-029 SHALL cover: start=100, stop=125, step=10 -> 100, 110, 120, 125 (clamp), then done_o; also start=300, stop=280, step=10 -> 300, 290, 280.
REQ-030 SHALL cover: start=65530, stop=65535, step=10 -> 65530, 65535, no wrap to a low value; also step=0 with go -> err_o=1, busy_o stays 0.
REQ-031 SHALL cover: continuous mode with 10->20, step=10, dwell=2 -> sequence 10, 20, 10, 20..., done_o never pulses.
REQ-032 SHALL cover: abort_i at 110 during the first scenario -> busy_o=0 next cycle, freq_o=110 held, no done_o; then reset mid-sweep -> all outputs 0.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency sweep controller: FSM encodings and
// default widths used by both the top level and the dwell timer.
package sweep_pkg;

    localparam int FREQ_W_DEF  = 16;
    localparam int DWELL_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell down-counter: load with D-1, pulses expire in the last cycle of the
// D-cycle hold; halt stops it immediately.
module dwell_timer
    import sweep_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               load,
    input  logic               halt,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    logic [DWELL_W-1:0] count_r;
    logic               run_r;

    assign expire = run_r & (count_r == {DWELL_W{1'b0}});

    // Countdown register; a load on the expiring cycle restarts seamlessly
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_r <= {DWELL_W{1'b0}};
            run_r   <= 1'b0;
        end else if (halt) begin
            count_r <= {DWELL_W{1'b0}};
            run_r   <= 1'b0;
        end else if (load) begin
            count_r <= load_val;
            run_r   <= 1'b1;
        end else if (run_r) begin
            if (count_r == {DWELL_W{1'b0}}) begin
                run_r <= 1'b0;
            end else begin
                count_r <= count_r - {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Linear frequency sweep controller driving a DDS frequency word: steps from
// start toward stop with a programmable dwell, clamping at stop.
module freq_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cfg_we_i,
    input  logic [FREQ_W-1:0]  cfg_start_i,
    input  logic [FREQ_W-1:0]  cfg_stop_i,
    input  logic [FREQ_W-1:0]  cfg_step_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic               cfg_cont_i,
    input  logic               go_i,
    input  logic               abort_i,
    output logic [FREQ_W-1:0]  freq_o,
    output logic               freq_upd_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    sweep_state_e       state_r, state_nxt_s;
    logic [FREQ_W-1:0]  start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               cont_r;
    logic               dir_up_r, dir_up_nxt_s;

    logic [FREQ_W-1:0]  freq_r, freq_nxt_s;
    logic               upd_r, upd_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               err_r, err_nxt_s;

    logic               cfg_cap_s;
    logic               tmr_load_s;
    logic               expire_s;
    logic [DWELL_W-1:0] dwell_ld_s;
    logic [FREQ_W:0]    sum_s, diff_s;
    logic [FREQ_W-1:0]  next_freq_s;

    assign freq_o     = freq_r;
    assign freq_upd_o = upd_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign err_o      = err_r;

    // A programmed dwell of 0 behaves as 1
    assign dwell_ld_s = (dwell_r == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                     : dwell_r - {{(DWELL_W-1){1'b0}}, 1'b1};

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .load     (tmr_load_s),
        .halt     (abort_i),
        .load_val (dwell_ld_s),
        .expire   (expire_s)
    );

    // Next frequency with one guard bit so wrap-around is caught and clamped
    always_comb begin
        sum_s  = {1'b0, freq_r} + {1'b0, step_r};
        diff_s = {1'b0, freq_r} - {1'b0, step_r};
        if (dir_up_r) begin
            if (sum_s[FREQ_W] || (sum_s[FREQ_W-1:0] > stop_r)) begin
                next_freq_s = stop_r;
            end else begin
                next_freq_s = sum_s[FREQ_W-1:0];
            end
        end else begin
            if (diff_s[FREQ_W] || (diff_s[FREQ_W-1:0] < stop_r)) begin
                next_freq_s = stop_r;
            end else begin
                next_freq_s = diff_s[FREQ_W-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s  = state_r;
        freq_nxt_s   = freq_r;
        upd_nxt_s    = 1'b0;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        err_nxt_s    = err_r;
        dir_up_nxt_s = dir_up_r;
        cfg_cap_s    = 1'b0;
        tmr_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                if (cfg_we_i) begin
                    cfg_cap_s = 1'b1;
                    err_nxt_s = 1'b0;
                end else begin
                    cfg_cap_s = 1'b0;
                end
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (go_i) begin
                    if (step_r == {FREQ_W{1'b0}}) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_DWELL;
                        freq_nxt_s   = start_r;
                        upd_nxt_s    = 1'b1;
                        busy_nxt_s   = 1'b1;
                        dir_up_nxt_s = (stop_r >= start_r);
                        tmr_load_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else if (expire_s) begin
                    if (freq_r == stop_r) begin
                        if (cont_r) begin
                            freq_nxt_s = start_r;
                            upd_nxt_s  = 1'b1;
                            tmr_load_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_DONE;
                            busy_nxt_s  = 1'b0;
                            done_nxt_s  = 1'b1;
                        end
                    end else begin
                        freq_nxt_s = next_freq_s;
                        upd_nxt_s  = 1'b1;
                        tmr_load_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_DWELL;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r  <= ST_IDLE;
            freq_r   <= {FREQ_W{1'b0}};
            upd_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            dir_up_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            freq_r   <= freq_nxt_s;
            upd_r    <= upd_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            dir_up_r <= dir_up_nxt_s;
        end
    end

    // Configuration registers, written only while idle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            start_r <= {FREQ_W{1'b0}};
            stop_r  <= {FREQ_W{1'b0}};
            step_r  <= {FREQ_W{1'b0}};
            dwell_r <= {DWELL_W{1'b0}};
            cont_r  <= 1'b0;
        end else if (cfg_cap_s) begin
            start_r <= cfg_start_i;
            stop_r  <= cfg_stop_i;
            step_r  <= cfg_step_i;
            dwell_r <= cfg_dwell_i;
            cont_r  <= cfg_cont_i;
        end else begin
            start_r <= start_r;
            stop_r  <= stop_r;
            step_r  <= step_r;
            dwell_r <= dwell_r;
            cont_r  <= cont_r;
        end
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Scoreboard bench for freq_sweep_ctrl: stimulus queues expected update/done
// events with their cycle; a negedge monitor pops and compares them.
module tb_freq_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_start = 16'd0, cfg_stop = 16'd0, cfg_step = 16'd0;
    logic [23:0] cfg_dwell = 24'd0;
    logic        cfg_cont = 1'b0;
    logic        go = 1'b0, abort = 1'b0;
    logic [15:0] freq;
    logic        freq_upd, busy, done, err;

    typedef struct {
        bit is_done;
        int fval;
        int cyc;
    } ev_t;

    ev_t sb_q[$];
    int  cycle_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    freq_sweep_ctrl dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .cfg_we_i    (cfg_we),
        .cfg_start_i (cfg_start),
        .cfg_stop_i  (cfg_stop),
        .cfg_step_i  (cfg_step),
        .cfg_dwell_i (cfg_dwell),
        .cfg_cont_i  (cfg_cont),
        .go_i        (go),
        .abort_i     (abort),
        .freq_o      (freq),
        .freq_upd_o  (freq_upd),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: every update or done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rstn && (freq_upd || done)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cycle %0d upd=%0d done=%0d freq=%0d, none expected",
                         cycle_cnt, freq_upd, done, freq);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                if (e.is_done != done || e.is_done == freq_upd || e.fval != int'(freq) || e.cyc != cycle_cnt) begin
                    errors++;
                    $display("FAIL event: got done=%0d upd=%0d freq=%0d @%0d, expected done=%0d freq=%0d @%0d",
                             done, freq_upd, freq, cycle_cnt, e.is_done, e.fval, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_upd(input int f, input int c);
        ev_t e;
        e.is_done = 1'b0; e.fval = f; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic exp_done(input int f, input int c);
        ev_t e;
        e.is_done = 1'b1; e.fval = f; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic write_cfg(input int s, input int p, input int st, input int dw, input bit cont);
        @(negedge clk);
        cfg_start = 16'(s); cfg_stop = 16'(p); cfg_step = 16'(st);
        cfg_dwell = 24'(dw); cfg_cont = cont; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic go_on(output int n);
        @(negedge clk);
        n  = cycle_cnt;
        go = 1'b1;
    endtask

    task automatic go_off();
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_cycle(input int c);
        for (int i = 0; i < 1000 && cycle_cnt < c; i++) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        int n;
        #1;
        check("rst_freq", int'(freq), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({freq_upd, done, err}), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Basic up sweep; a second go and a config write mid-sweep are ignored
        write_cfg(100, 130, 10, 4, 1'b0);
        go_on(n);
        exp_upd(100, n + 1); exp_upd(110, n + 5); exp_upd(120, n + 9); exp_upd(130, n + 13);
        exp_done(130, n + 17);
        go_off();
        check("busy_after_go", int'(busy), 1);
        wait_cycle(n + 6);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        write_cfg(7, 9, 0, 1, 1'b0);
        drain("sweep_a_drain");
        check("sweep_a_busy_end", int'(busy), 0);
        check("sweep_a_err", int'(err), 0);

        // Rerun the unchanged config and abort while at 110
        go_on(n);
        exp_upd(100, n + 1); exp_upd(110, n + 5);
        go_off();
        wait_cycle(n + 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_freq", int'(freq), 110);
        repeat (20) @(negedge clk);
        check("abort_quiet", sb_q.size(), 0);
        check("abort_freq_held", int'(freq), 110);

        // Clamp at stop going up, dwell 0 acts as 1
        write_cfg(100, 125, 10, 0, 1'b0);
        go_on(n);
        exp_upd(100, n + 1); exp_upd(110, n + 2); exp_upd(120, n + 3); exp_upd(125, n + 4);
        exp_done(125, n + 5);
        go_off();
        drain("clamp_up_drain");

        // Down sweep
        write_cfg(300, 280, 10, 2, 1'b0);
        go_on(n);
        exp_upd(300, n + 1); exp_upd(290, n + 3); exp_upd(280, n + 5);
        exp_done(280, n + 7);
        go_off();
        drain("down_drain");

        // Overflow clamps to stop rather than wrapping
        write_cfg(65530, 65535, 10, 1, 1'b0);
        go_on(n);
        exp_upd(65530, n + 1); exp_upd(65535, n + 2);
        exp_done(65535, n + 3);
        go_off();
        drain("ovf_drain");

        // Single-point sweep
        write_cfg(50, 50, 5, 3, 1'b0);
        go_on(n);
        exp_upd(50, n + 1);
        exp_done(50, n + 4);
        go_off();
        drain("single_drain");

        // Zero step is a config error; the next write clears it
        write_cfg(10, 20, 0, 1, 1'b0);
        go_on(n);
        go_off();
        check("step0_err", int'(err), 1);
        repeat (3) @(negedge clk);
        check("step0_busy", int'(busy), 0);
        write_cfg(10, 20, 10, 2, 1'b1);
        check("err_cleared", int'(err), 0);

        // Continuous sweep, ended by abort
        go_on(n);
        exp_upd(10, n + 1); exp_upd(20, n + 3); exp_upd(10, n + 5);
        exp_upd(20, n + 7); exp_upd(10, n + 9);
        go_off();
        wait_cycle(n + 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("cont_abort_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("cont_quiet", sb_q.size(), 0);
        check("cont_freq_held", int'(freq), 10);

        // Reset mid-sweep clears outputs and config
        write_cfg(100, 130, 10, 4, 1'b0);
        go_on(n);
        exp_upd(100, n + 1); exp_upd(110, n + 5);
        go_off();
        wait_cycle(n + 7);
        #2 rstn = 1'b0;
        #1;
        check("midrst_freq", int'(freq), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_flags", int'({freq_upd, done, err}), 0);
        check("midrst_seen", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (25) @(negedge clk);
        check("postrst_quiet", sb_q.size(), 0);
        check("postrst_busy", int'(busy), 0);
        check("postrst_freq", int'(freq), 0);
        go_on(n);
        go_off();
        check("postrst_cfg_cleared_err", int'(err), 1);
        check("postrst_no_sweep", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
